pkmc_sdramctrl_bankopen: RTL

Bank-open sequencer for the PKMC SDRAM controller: the command-issuing counterpart to the active-bank tracker. Given a bank/row access request, it consults its own open-row table, issues PRECHARGE and ACTIVATE commands with tRP/tRCD spacing, and acknowledges when the requested row is open. It also services precharge-all requests ahead of refresh. Its command output feeds the controller's SDRAM command mux.

---
 rtl/pkmc_sdramctrl_bankopen_pkg.sv | 33 +++
 rtl/pkmc_sdramctrl_rowtable.sv | 52 +++++
 rtl/pkmc_sdramctrl_bankopen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pkmc_sdramctrl_bankopen_pkg.sv
// PKMC SDRAM bank-open sequencer: shared command codes,
// FSM encodings and default timing.
package pkmc_sdramctrl_bankopen_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_ACT  = 2'd1,
    CMD_PRE  = 2'd2,
    CMD_PALL = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_RP   = 3'd2,
    ST_ACT       = 3'd3,
    ST_WAIT_RCD  = 3'd4,
    ST_ACK       = 3'd5,
    ST_PALL      = 3'd6,
    ST_WAIT_PALL = 3'd7
  } state_e;

  localparam int TRP_DEF  = 2;
  localparam int TRCD_DEF = 2;
  localparam int TMR_W    = 4;

  function automatic logic [TMR_W-1:0] wait_load(
    input int t
  );
    return TMR_W'(t - 1);
  endfunction

endpackage

// File: rtl/pkmc_sdramctrl_rowtable.sv
// Per-bank open bit and open-row register, updated only by
// command handshakes from the sequencer.
module pkmc_sdramctrl_rowtable
  import pkmc_sdramctrl_bankopen_pkg::*;
#(
  parameter int BANKS  = 4,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BANK_W-1:0] lk_bank_i,
  input  logic [ROW_W-1:0]  lk_row_i,
  output logic              lk_open_o,
  output logic              lk_hit_o,
  input  logic              set_i,
  input  logic [BANK_W-1:0] set_bank_i,
  input  logic [ROW_W-1:0]  set_row_i,
  input  logic              clr_i,
  input  logic [BANK_W-1:0] clr_bank_i,
  input  logic              clr_all_i,
  output logic [BANKS-1:0]  open_vec_o
);

  logic [BANKS-1:0] open_q;
  logic [ROW_W-1:0] row_q [BANKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < BANKS; i++) begin
        row_q[i] <= '0;
      end
    end else if (clr_all_i) begin
      open_q <= '0;
    end else begin
      if (clr_i) begin
        open_q[clr_bank_i] <= 1'b0;
      end
      if (set_i) begin
        open_q[set_bank_i] <= 1'b1;
        row_q[set_bank_i]  <= set_row_i;
      end
    end
  end

  assign lk_open_o  = open_q[lk_bank_i];
  assign lk_hit_o   = lk_open_o &&
                      (row_q[lk_bank_i] == lk_row_i);
  assign open_vec_o = open_q;

endmodule

// File: rtl/pkmc_sdramctrl_bankopen.sv
// Bank-open sequencer: issues PRE/ACT/PALL with tRP/tRCD
// spacing and acks once the requested row is open.
module pkmc_sdramctrl_bankopen
  import pkmc_sdramctrl_bankopen_pkg::*;
#(
  parameter int BANKS  = 4,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int TRP    = TRP_DEF,
  parameter int TRCD   = TRCD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [BANK_W-1:0] req_bank,
  input  logic [ROW_W-1:0]  req_row,
  output logic              ack,
  input  logic              pall_req,
  output logic              pall_done,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [BANKS-1:0]  open_vec
);

  localparam logic [TMR_W-1:0] RP_LD  = wait_load(TRP);
  localparam logic [TMR_W-1:0] RCD_LD = wait_load(TRCD);

  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic               ack_q;
  logic               pall_done_q;
  logic               cmd_valid_q;
  cmd_e               cmd_q;
  logic [BANK_W-1:0]  cmd_bank_q;
  logic [ROW_W-1:0]   cmd_row_q;

  logic               hs;
  logic               lk_open;
  logic               lk_hit;
  logic               tbl_set;
  logic               tbl_clr;
  logic               tbl_clr_all;
  logic               tmr_done;

  assign hs       = cmd_valid_q & cmd_ready;
  assign tmr_done = (timer_q <= TMR_W'(1));

  assign tbl_set     = (state_q == ST_ACT)  && hs;
  assign tbl_clr     = (state_q == ST_PRE)  && hs;
  assign tbl_clr_all = (state_q == ST_PALL) && hs;

  pkmc_sdramctrl_rowtable #(
    .BANKS  (BANKS),
    .BANK_W (BANK_W),
    .ROW_W  (ROW_W)
  ) u_rowtable (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_bank_i  (req_bank),
    .lk_row_i   (req_row),
    .lk_open_o  (lk_open),
    .lk_hit_o   (lk_hit),
    .set_i      (tbl_set),
    .set_bank_i (cmd_bank_q),
    .set_row_i  (cmd_row_q),
    .clr_i      (tbl_clr),
    .clr_bank_i (cmd_bank_q),
    .clr_all_i  (tbl_clr_all),
    .open_vec_o (open_vec)
  );

  // Wait states exit as the timer steps to 0, so the
  // ack/ACT register lands exactly tRP/tRCD after a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      ack_q       <= 1'b0;
      pall_done_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
    end else begin
      ack_q       <= 1'b0;
      pall_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pall_req) begin
            if (|open_vec) begin
              state_q     <= ST_PALL;
              cmd_valid_q <= 1'b1;
              cmd_q       <= CMD_PALL;
              cmd_bank_q  <= '0;
              cmd_row_q   <= '0;
            end else begin
              state_q     <= ST_ACK;
              pall_done_q <= 1'b1;
            end
          end else if (req) begin
            if (lk_hit) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else if (lk_open) begin
              state_q     <= ST_PRE;
              cmd_valid_q <= 1'b1;
              cmd_q       <= CMD_PRE;
              cmd_bank_q  <= req_bank;
              cmd_row_q   <= '0;
            end else begin
              state_q     <= ST_ACT;
              cmd_valid_q <= 1'b1;
              cmd_q       <= CMD_ACT;
              cmd_bank_q  <= req_bank;
              cmd_row_q   <= req_row;
            end
          end
        end
        ST_PRE: begin
          if (hs) begin
            if (RP_LD == '0) begin
              state_q    <= ST_ACT;
              cmd_q      <= CMD_ACT;
              cmd_bank_q <= req_bank;
              cmd_row_q  <= req_row;
            end else begin
              state_q     <= ST_WAIT_RP;
              timer_q     <= RP_LD;
              cmd_valid_q <= 1'b0;
              cmd_q       <= CMD_NOP;
              cmd_bank_q  <= '0;
            end
          end
        end
        ST_WAIT_RP: begin
          timer_q <= timer_q - TMR_W'(1);
          if (tmr_done) begin
            state_q     <= ST_ACT;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_ACT;
            cmd_bank_q  <= req_bank;
            cmd_row_q   <= req_row;
          end
        end
        ST_ACT: begin
          if (hs) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            if (RCD_LD == '0) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= ST_WAIT_RCD;
              timer_q <= RCD_LD;
            end
          end
        end
        ST_WAIT_RCD: begin
          timer_q <= timer_q - TMR_W'(1);
          if (tmr_done) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
        end
        ST_PALL: begin
          if (hs) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            if (RP_LD == '0) begin
              state_q     <= ST_ACK;
              pall_done_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT_PALL;
              timer_q <= RP_LD;
            end
          end
        end
        ST_WAIT_PALL: begin
          timer_q <= timer_q - TMR_W'(1);
          if (tmr_done) begin
            state_q     <= ST_ACK;
            pall_done_q <= 1'b1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign pall_done = pall_done_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;

endmodule
